// File: rtl/alu_muldiv_unit.sv
// Execute unit: single-cycle RV32I/RV64I ALU and branch compare, plus an iterative
// shift-add multiplier / restoring divider for the M extension, with valid/ready on both sides.
module alu_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            Valid_i,
    output logic            Ready_o,
    input  logic [1:0]      ALUOp_i,
    input  logic [2:0]      Funct3_i,
    input  logic [6:0]      Funct7_i,
    input  logic [XLEN-1:0] OperandA_i,
    input  logic [XLEN-1:0] OperandB_i,
    output logic            Valid_o,
    input  logic            Ready_i,
    output logic [XLEN-1:0] Result_o,
    output logic            Flag_o
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] LAST_C    = SHW'(XLEN - 1);
    localparam logic [SHW-1:0] CNT_ONE_C = {{(SHW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t            state_r, state_s;
    logic [XLEN-1:0]   hi_r, hi_s, lo_r, lo_s, dvs_r, dvs_s;
    logic [SHW-1:0]    cnt_r, cnt_s;
    logic [2:0]        f3_r, f3_s;
    logic              a_neg_r, a_neg_s, b_neg_r, b_neg_s, dz_r, dz_s;
    logic [XLEN-1:0]   result_r, result_s;
    logic              flag_r, flag_s;

    logic [XLEN-1:0]   base_res_s;
    logic              base_flag_s, is_mop_s;
    logic [SHW-1:0]    shamt_s;
    logic              a_sgn_s, b_sgn_s, a_neg_in_s, b_neg_in_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s;
    logic [XLEN:0]     mul_sum_s, rem_sh_s;
    logic [XLEN-1:0]   rem_sub_s, hi_it_s, lo_it_s;
    logic [2*XLEN-1:0] prod_s, prod_fix_s;
    logic [XLEN-1:0]   quo_fix_s, rem_fix_s, m_res_s;

    assign shamt_s = OperandB_i[SHW-1:0];

    // Operand signedness per M funct3, and magnitudes fed to the engine
    assign a_sgn_s    = ~(Funct3_i[0] & (Funct3_i[1] | Funct3_i[2]));
    assign b_sgn_s    = a_sgn_s & (Funct3_i != 3'b010);
    assign a_neg_in_s = a_sgn_s & OperandA_i[XLEN-1];
    assign b_neg_in_s = b_sgn_s & OperandB_i[XLEN-1];
    assign a_mag_s    = a_neg_in_s ? -OperandA_i : OperandA_i;
    assign b_mag_s    = b_neg_in_s ? -OperandB_i : OperandB_i;

    // Single-cycle ALU, branch compare and M-op detection
    always_comb begin
        base_res_s  = {XLEN{1'b0}};
        base_flag_s = 1'b0;
        is_mop_s    = 1'b0;
        case (ALUOp_i)
            2'b00: begin
                if (Funct7_i == 7'b0000000) begin
                    case (Funct3_i)
                        3'b000:  base_res_s = OperandA_i + OperandB_i;
                        3'b001:  base_res_s = OperandA_i << shamt_s;
                        3'b010:  base_res_s = {{(XLEN-1){1'b0}}, ($signed(OperandA_i) < $signed(OperandB_i))};
                        3'b011:  base_res_s = {{(XLEN-1){1'b0}}, (OperandA_i < OperandB_i)};
                        3'b100:  base_res_s = OperandA_i ^ OperandB_i;
                        3'b101:  base_res_s = OperandA_i >> shamt_s;
                        3'b110:  base_res_s = OperandA_i | OperandB_i;
                        3'b111:  base_res_s = OperandA_i & OperandB_i;
                        default: base_res_s = {XLEN{1'b0}};
                    endcase
                end else if (Funct7_i == 7'b0100000) begin
                    case (Funct3_i)
                        3'b000:  base_res_s = OperandA_i - OperandB_i;
                        3'b101:  base_res_s = $signed(OperandA_i) >>> shamt_s;
                        default: base_res_s = {XLEN{1'b0}};
                    endcase
                end else if (Funct7_i == 7'b0000001) begin
                    is_mop_s = 1'b1;
                end else begin
                    base_res_s = {XLEN{1'b0}};
                end
            end
            2'b01: base_res_s = OperandA_i + OperandB_i;
            2'b10: begin
                case (Funct3_i)
                    3'b000:  base_flag_s = (OperandA_i == OperandB_i);
                    3'b001:  base_flag_s = (OperandA_i != OperandB_i);
                    3'b100:  base_flag_s = ($signed(OperandA_i) < $signed(OperandB_i));
                    3'b101:  base_flag_s = ($signed(OperandA_i) >= $signed(OperandB_i));
                    3'b110:  base_flag_s = (OperandA_i < OperandB_i);
                    3'b111:  base_flag_s = (OperandA_i >= OperandB_i);
                    default: base_flag_s = 1'b0;
                endcase
            end
            2'b11:   base_res_s = OperandB_i;
            default: base_res_s = {XLEN{1'b0}};
        endcase
    end

    // One engine step: hi/lo is the product shift pair or the remainder/quotient pair
    always_comb begin
        hi_it_s   = hi_r;
        lo_it_s   = lo_r;
        mul_sum_s = {1'b0, hi_r} + {1'b0, (lo_r[0] ? dvs_r : {XLEN{1'b0}})};
        rem_sh_s  = {hi_r, lo_r[XLEN-1]};
        rem_sub_s = rem_sh_s[XLEN-1:0] - dvs_r;
        if (f3_r[2]) begin
            if (rem_sh_s >= {1'b0, dvs_r}) begin
                hi_it_s = rem_sub_s;
                lo_it_s = {lo_r[XLEN-2:0], 1'b1};
            end else begin
                hi_it_s = rem_sh_s[XLEN-1:0];
                lo_it_s = {lo_r[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_it_s = mul_sum_s[XLEN:1];
            lo_it_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Sign correction and divide-by-zero override applied to the final step's values
    always_comb begin
        prod_s     = {hi_it_s, lo_it_s};
        prod_fix_s = (a_neg_r ^ b_neg_r) ? -prod_s : prod_s;
        quo_fix_s  = (a_neg_r ^ b_neg_r) ? -lo_it_s : lo_it_s;
        rem_fix_s  = a_neg_r ? -hi_it_s : hi_it_s;
        case (f3_r)
            3'b000:                 m_res_s = prod_fix_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: m_res_s = prod_fix_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         m_res_s = dz_r ? {XLEN{1'b1}} : quo_fix_s;
            3'b110, 3'b111:         m_res_s = rem_fix_s;
            default:                m_res_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state and datapath register update decisions
    always_comb begin
        state_s  = state_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        dvs_s    = dvs_r;
        cnt_s    = cnt_r;
        f3_s     = f3_r;
        a_neg_s  = a_neg_r;
        b_neg_s  = b_neg_r;
        dz_s     = dz_r;
        result_s = result_r;
        flag_s   = flag_r;
        case (state_r)
            IDLE: begin
                if (Valid_i) begin
                    if (is_mop_s) begin
                        state_s = CALC;
                        f3_s    = Funct3_i;
                        hi_s    = {XLEN{1'b0}};
                        lo_s    = a_mag_s;
                        dvs_s   = b_mag_s;
                        cnt_s   = {SHW{1'b0}};
                        a_neg_s = a_neg_in_s;
                        b_neg_s = b_neg_in_s;
                        dz_s    = (OperandB_i == {XLEN{1'b0}});
                    end else begin
                        state_s  = DONE;
                        result_s = base_res_s;
                        flag_s   = base_flag_s;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                hi_s  = hi_it_s;
                lo_s  = lo_it_s;
                cnt_s = cnt_r + CNT_ONE_C;
                if (cnt_r == LAST_C) begin
                    state_s  = DONE;
                    result_s = m_res_s;
                    flag_s   = 1'b0;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (Ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= IDLE;
            hi_r     <= {XLEN{1'b0}};
            lo_r     <= {XLEN{1'b0}};
            dvs_r    <= {XLEN{1'b0}};
            cnt_r    <= {SHW{1'b0}};
            f3_r     <= 3'b000;
            a_neg_r  <= 1'b0;
            b_neg_r  <= 1'b0;
            dz_r     <= 1'b0;
            result_r <= {XLEN{1'b0}};
            flag_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            hi_r     <= hi_s;
            lo_r     <= lo_s;
            dvs_r    <= dvs_s;
            cnt_r    <= cnt_s;
            f3_r     <= f3_s;
            a_neg_r  <= a_neg_s;
            b_neg_r  <= b_neg_s;
            dz_r     <= dz_s;
            result_r <= result_s;
            flag_r   <= flag_s;
        end
    end

    assign Ready_o  = (state_r == IDLE);
    assign Valid_o  = (state_r == DONE);
    assign Result_o = result_r;
    assign Flag_o   = flag_r;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit: directed vector table, handshake/reset
// sequences, and random operations checked against a plain-arithmetic reference model.
module tb_alu_muldiv_unit;
    logic        clk;
    logic        rst_n;
    logic        valid_in, ready_out, valid_out, ready_in, flag_out;
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] opa, opb, result_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        flag;
        int          lat;
    } vec_t;

    vec_t vecs[25];

    alu_muldiv_unit #(.XLEN(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .Valid_i(valid_in), .Ready_o(ready_out),
        .ALUOp_i(aluop), .Funct3_i(f3), .Funct7_i(f7),
        .OperandA_i(opa), .OperandB_i(opb),
        .Valid_o(valid_out), .Ready_i(ready_in), .Result_o(result_out), .Flag_o(flag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference model: direct arithmetic on 64-bit integers
    task automatic model(input logic [1:0] op, input logic [2:0] fn3, input logic [6:0] fn7,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic f, output int lat);
        longint sa, sb, za, zb, p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        za = longint'({32'h0, a});
        zb = longint'({32'h0, b});
        ia = int'(a);
        ib = int'(b);
        r = 32'h0; f = 1'b0; lat = 1;
        p = 64'sd0;
        case (op)
            2'b00: begin
                if (fn7 == 7'h00) begin
                    case (fn3)
                        3'd0: r = a + b;
                        3'd1: r = a << b[4:0];
                        3'd2: r = (ia < ib) ? 32'd1 : 32'd0;
                        3'd3: r = (a < b) ? 32'd1 : 32'd0;
                        3'd4: r = a ^ b;
                        3'd5: r = a >> b[4:0];
                        3'd6: r = a | b;
                        default: r = a & b;
                    endcase
                end else if (fn7 == 7'h20) begin
                    if (fn3 == 3'd0) r = a - b;
                    else if (fn3 == 3'd5) r = ia >>> b[4:0];
                    else r = 32'h0;
                end else if (fn7 == 7'h01) begin
                    lat = 33;
                    case (fn3)
                        3'd0: begin p = sa * sb; r = p[31:0]; end
                        3'd1: begin p = sa * sb; r = p[63:32]; end
                        3'd2: begin p = sa * zb; r = p[63:32]; end
                        3'd3: begin p = za * zb; r = p[63:32]; end
                        3'd4: begin
                            if (b == 32'h0) r = 32'hFFFFFFFF;
                            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
                            else r = ia / ib;
                        end
                        3'd5: r = (b == 32'h0) ? 32'hFFFFFFFF : a / b;
                        3'd6: begin
                            if (b == 32'h0) r = a;
                            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
                            else r = ia % ib;
                        end
                        default: r = (b == 32'h0) ? a : a % b;
                    endcase
                end else begin
                    r = 32'h0;
                end
            end
            2'b01: r = a + b;
            2'b10: begin
                case (fn3)
                    3'd0: f = (a == b);
                    3'd1: f = (a != b);
                    3'd4: f = (ia < ib);
                    3'd5: f = (ia >= ib);
                    3'd6: f = (a < b);
                    3'd7: f = (a >= b);
                    default: f = 1'b0;
                endcase
            end
            default: r = b;
        endcase
    endtask

    // Issue one op, measure edges from accept to Valid_o, then complete the handshake
    task automatic run_op(input logic [1:0] op, input logic [2:0] fn3, input logic [6:0] fn7,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic f, output int lat);
        int w;
        w = 0;
        while (!ready_out && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 100) check("ready_wait_timeout", {31'b0, ready_out}, 32'd1);
        valid_in = 1'b1; aluop = op; f3 = fn3; f7 = fn7; opa = a; opb = b;
        @(posedge clk); #1;
        valid_in = 1'b0;
        opa = $urandom; opb = $urandom;
        lat = 1;
        while (!valid_out && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        r = result_out;
        f = flag_out;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] r, er;
        logic        f, ef;
        int          lat, elat;
        logic        saw_valid;
        logic [1:0]  rop;
        logic [2:0]  rf3;
        logic [6:0]  rf7;
        logic [31:0] ra, rb;

        vecs[0]  = '{2'b00, 3'b000, 7'h00, 32'd20, 32'd30, 32'd50, 1'b0, 1};
        vecs[1]  = '{2'b00, 3'b000, 7'h20, 32'd20, 32'd30, 32'hFFFFFFF6, 1'b0, 1};
        vecs[2]  = '{2'b00, 3'b101, 7'h20, 32'hFFFFFFEC, 32'd2, 32'hFFFFFFFB, 1'b0, 1};
        vecs[3]  = '{2'b00, 3'b101, 7'h00, 32'd20, 32'd2, 32'd5, 1'b0, 1};
        vecs[4]  = '{2'b00, 3'b011, 7'h00, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 1};
        vecs[5]  = '{2'b11, 3'b000, 7'h00, 32'd0, 32'h12345000, 32'h12345000, 1'b0, 1};
        vecs[6]  = '{2'b00, 3'b000, 7'h01, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33};
        vecs[7]  = '{2'b00, 3'b001, 7'h01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 33};
        vecs[8]  = '{2'b00, 3'b011, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33};
        vecs[9]  = '{2'b00, 3'b100, 7'h01, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 1'b0, 33};
        vecs[10] = '{2'b00, 3'b110, 7'h01, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 1'b0, 33};
        vecs[11] = '{2'b00, 3'b101, 7'h01, 32'd100, 32'd0, 32'hFFFFFFFF, 1'b0, 33};
        vecs[12] = '{2'b00, 3'b111, 7'h01, 32'd100, 32'd0, 32'd100, 1'b0, 33};
        vecs[13] = '{2'b00, 3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33};
        vecs[14] = '{2'b00, 3'b110, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 33};
        vecs[15] = '{2'b10, 3'b100, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1};
        vecs[16] = '{2'b10, 3'b110, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1};
        vecs[17] = '{2'b10, 3'b000, 7'h00, 32'd20, 32'd20, 32'd0, 1'b1, 1};
        vecs[18] = '{2'b10, 3'b001, 7'h00, 32'd20, 32'd20, 32'd0, 1'b0, 1};
        vecs[19] = '{2'b00, 3'b000, 7'h02, 32'd20, 32'd30, 32'd0, 1'b0, 1};
        vecs[20] = '{2'b01, 3'b010, 7'h00, 32'h1000, 32'h24, 32'h1024, 1'b0, 1};
        vecs[21] = '{2'b10, 3'b010, 7'h00, 32'd5, 32'd5, 32'd0, 1'b0, 1};
        vecs[22] = '{2'b00, 3'b100, 7'h01, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1'b0, 33};
        vecs[23] = '{2'b00, 3'b110, 7'h01, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1'b0, 33};
        vecs[24] = '{2'b00, 3'b001, 7'h00, 32'd1, 32'h3F, 32'h80000000, 1'b0, 1};

        rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        aluop = 2'b00; f3 = 3'b000; f7 = 7'h00; opa = 32'h0; opb = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_ready", {31'b0, ready_out}, 32'd1);
        check("reset_valid", {31'b0, valid_out}, 32'd0);
        check("reset_result", result_out, 32'd0);
        check("reset_flag", {31'b0, flag_out}, 32'd0);

        for (int i = 0; i < 25; i++) begin
            run_op(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, r, f, lat);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_flag", i), {31'b0, f}, {31'b0, vecs[i].flag});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Downstream stall: result held, no accept, Valid_i pulses ignored
        ready_in = 1'b0;
        valid_in = 1'b1; aluop = 2'b00; f3 = 3'b000; f7 = 7'h00; opa = 32'd3; opb = 32'd4;
        @(posedge clk); #1;
        check("hold_valid_first", {31'b0, valid_out}, 32'd1);
        check("hold_result_first", result_out, 32'd7);
        for (int k = 0; k < 5; k++) begin
            valid_in = (k % 2 == 0);
            aluop = 2'b11; opb = $urandom;
            @(posedge clk); #1;
            check($sformatf("hold%0d_result", k), result_out, 32'd7);
            check($sformatf("hold%0d_ready", k), {31'b0, ready_out}, 32'd0);
            check($sformatf("hold%0d_valid", k), {31'b0, valid_out}, 32'd1);
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk); #1;
        check("hold_release_valid", {31'b0, valid_out}, 32'd0);
        check("hold_release_ready", {31'b0, ready_out}, 32'd1);
        @(posedge clk); #1;
        check("hold_no_second_result", {31'b0, valid_out}, 32'd0);

        // Reset in the middle of a divide
        valid_in = 1'b1; aluop = 2'b00; f3 = 3'b100; f7 = 7'h01; opa = 32'd1000; opb = 32'd7;
        @(posedge clk); #1;
        valid_in = 1'b0;
        check("calc_ready_low", {31'b0, ready_out}, 32'd0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_valid", {31'b0, valid_out}, 32'd0);
        check("abort_ready", {31'b0, ready_out}, 32'd1);
        check("abort_result", result_out, 32'd0);
        check("abort_flag", {31'b0, flag_out}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (valid_out) saw_valid = 1'b1;
        end
        check("abort_no_valid", {31'b0, saw_valid}, 32'd0);
        run_op(2'b00, 3'b000, 7'h00, 32'd5, 32'd6, r, f, lat);
        check("post_abort_add", r, 32'd11);
        check("post_abort_latency", lat, 32'd1);

        // Random operations against the reference model
        for (int n = 0; n < 60; n++) begin
            rop = 2'($urandom_range(0, 3));
            rf3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: rf7 = 7'h00;
                1: rf7 = 7'h20;
                2, 3: rf7 = 7'h01;
                default: rf7 = 7'($urandom);
            endcase
            if (rf7 == 7'h01) rop = 2'b00;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: rb = 32'h0;
                2: rb = 32'hFFFFFFFF;
                3: rb = 32'($urandom_range(1, 20));
                default: ra = ra;
            endcase
            model(rop, rf3, rf7, ra, rb, er, ef, elat);
            run_op(rop, rf3, rf7, ra, rb, r, f, lat);
            check($sformatf("rnd%0d_result op=%0d f3=%0d f7=%h a=%h b=%h", n, rop, rf3, rf7, ra, rb), r, er);
            check($sformatf("rnd%0d_flag", n), {31'b0, f}, {31'b0, ef});
            check($sformatf("rnd%0d_latency", n), lat, elat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
